// File: rtl/nrzi_pkg.sv
// rtl/nrzi_pkg.sv - shared state encoding, default parameters and width helper for the NRZI frame receiver
package nrzi_pkg;

    localparam int          WIDTH_DEF     = 8;
    localparam logic [7:0]  SYNC_DEF      = 8'hA5;
    localparam int          FRAME_LEN_DEF = 4;

    typedef logic [0:0] state_t;

    localparam state_t ST_HUNT = 1'b0;
    localparam state_t ST_DATA = 1'b1;

    // Width needed to hold a count from 0 to n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nrzi_bit_decode.sv
// rtl/nrzi_bit_decode.sv - toggle-encoded line to bit stream decoder (bit = line ^ previous line)
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   bit_en      - sample strobe, line_in consumed only when high
//   line_in     - toggle-encoded line level
//   bit_o       - decoded bit, meaningful when bit_vld_o is high
//   bit_vld_o   - decoded bit is valid this cycle
module nrzi_bit_decode (
    input  logic clk,
    input  logic reset,
    input  logic bit_en,
    input  logic line_in,
    output logic bit_o,
    output logic bit_vld_o
);

    // Resets to 0 to match the transmit flip-flop's reset level.
    logic prev_line_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_line_q <= 1'b0;
        end else if (bit_en) begin
            prev_line_q <= line_in;
        end
    end

    assign bit_o     = line_in ^ prev_line_q;
    assign bit_vld_o = bit_en;

endmodule

// File: rtl/nrzi_frame_rx.sv
// rtl/nrzi_frame_rx.sv - NRZI receive path: sync word hunt and fixed-length frame deserializer
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   bit_en      - sample strobe from the line sampler
//   line_in     - toggle-encoded line level
//   data_out    - last completed data word, MSB first
//   data_valid  - one-cycle pulse, data_out is new
//   sync_found  - one-cycle pulse on sync word match
//   in_frame    - high while deserializing frame data
//   word_cnt    - data words received in the current frame
module nrzi_frame_rx
    import nrzi_pkg::*;
#(
    parameter int               WIDTH     = WIDTH_DEF,
    parameter logic [WIDTH-1:0] SYNC_WORD = SYNC_DEF,
    parameter int               FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            bit_en,
    input  logic                            line_in,
    output logic [WIDTH-1:0]                data_out,
    output logic                            data_valid,
    output logic                            sync_found,
    output logic                            in_frame,
    output logic [cnt_width(FRAME_LEN)-1:0] word_cnt
);

    localparam int FW = $clog2(WIDTH + 1);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = cnt_width(FRAME_LEN);

    localparam logic [FW-1:0] FILL_FULL = FW'(WIDTH);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [CW-1:0] WORD_LAST = CW'(FRAME_LEN);

    logic bit_w;
    logic bit_vld_w;

    nrzi_bit_decode u_decode (
        .clk       (clk),
        .reset     (reset),
        .bit_en    (bit_en),
        .line_in   (line_in),
        .bit_o     (bit_w),
        .bit_vld_o (bit_vld_w)
    );

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [CW-1:0]    wcnt_q, wcnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             sync_q, sync_d;
    logic             in_frame_q;
    logic [WIDTH-1:0] sr_upd;

    assign sr_upd = {sr_q[WIDTH-2:0], bit_w};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        sync_d  = 1'b0;

        if (bit_vld_w) begin
            sr_d = sr_upd;
            case (state_q)
                ST_HUNT: begin
                    if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + 1'b1;
                    end
                    // Sliding search: every bit is a candidate once WIDTH fresh bits are in.
                    if (fill_d == FILL_FULL && sr_upd == SYNC_WORD) begin
                        state_d = ST_DATA;
                        bcnt_d  = '0;
                        wcnt_d  = '0;
                        sync_d  = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bcnt_q == BIT_LAST) begin
                        bcnt_d  = '0;
                        dout_d  = sr_upd;
                        valid_d = 1'b1;
                        wcnt_d  = wcnt_q + 1'b1;
                        // Frame tail is flushed so it can never contribute to a sync match.
                        if (wcnt_d == WORD_LAST) begin
                            state_d = ST_HUNT;
                            fill_d  = '0;
                            sr_d    = '0;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_HUNT;
            sr_q       <= '0;
            fill_q     <= '0;
            bcnt_q     <= '0;
            wcnt_q     <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            sync_q     <= 1'b0;
            in_frame_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            fill_q     <= fill_d;
            bcnt_q     <= bcnt_d;
            wcnt_q     <= wcnt_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            sync_q     <= sync_d;
            in_frame_q <= (state_d == ST_DATA);
        end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign sync_found = sync_q;
    assign in_frame   = in_frame_q;
    assign word_cnt   = wcnt_q;

endmodule

// File: tb/tb_nrzi_frame_rx.sv
// tb/tb_nrzi_frame_rx.sv - directed self-checking bench for nrzi_frame_rx
`timescale 1ns/1ps
module tb_nrzi_frame_rx;

    logic       clk;
    logic       reset;
    logic       bit_en;
    logic       line_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       sync_found;
    logic       in_frame;
    logic [2:0] word_cnt;

    nrzi_frame_rx dut (
        .clk        (clk),
        .reset      (reset),
        .bit_en     (bit_en),
        .line_in    (line_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .sync_found (sync_found),
        .in_frame   (in_frame),
        .word_cnt   (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int         valid_cnt = 0;
    int         sync_cnt  = 0;
    int         wide_cnt  = 0;
    logic       prev_valid = 1'b0;
    logic       prev_sync  = 1'b0;
    logic [7:0] words [$];

    always @(posedge clk) begin
        if (data_valid) begin
            valid_cnt++;
            words.push_back(data_out);
        end
        if (sync_found) sync_cnt++;
        if ((data_valid && prev_valid) || (sync_found && prev_sync)) wide_cnt++;
        prev_valid = data_valid;
        prev_sync  = sync_found;
    end

    logic line_lvl = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the bit consumed.
    task automatic drive_lvl(input logic lvl);
        line_lvl = lvl;
        line_in  = lvl;
        bit_en   = 1'b1;
        @(negedge clk);
        bit_en   = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        drive_lvl(line_lvl ^ b);
    endtask

    // Idle cycles toggle the line to garbage; it must be ignored without bit_en.
    task automatic idle(input int n);
        repeat (n) begin
            line_in = ~line_lvl;
            @(negedge clk);
        end
        line_in = line_lvl;
    endtask

    task automatic send_word(input logic [7:0] w, input int gap);
        for (int i = 7; i >= 0; i--) begin
            drive_bit(w[i]);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        line_lvl = 1'b0;
        line_in  = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    logic [7:0] fw [4];
    logic [7:0] tw [4];
    logic [7:0] rw [4];
    int s0, v0, q0;

    initial begin
        fw[0] = 8'h3C; fw[1] = 8'hFF; fw[2] = 8'h00; fw[3] = 8'h81;
        tw[0] = 8'h5A; tw[1] = 8'hC3; tw[2] = 8'h01; tw[3] = 8'h80;
        rw[0] = 8'hDE; rw[1] = 8'hAD; rw[2] = 8'hBE; rw[3] = 8'hEF;

        reset   = 1'b1;
        bit_en  = 1'b0;
        line_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_data_out",   data_out,   0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_sync_found", sync_found, 0);
        chk("rst_in_frame",   in_frame,   0);
        chk("rst_word_cnt",   word_cnt,   0);
        reset = 1'b0;
        @(negedge clk);

        // Only 7 bits after reset, ending like the sync word: no match allowed.
        drive_bit(0); drive_bit(1); drive_bit(0); drive_bit(0);
        drive_bit(1); drive_bit(0); drive_bit(1);
        idle(2);
        chk("early_no_sync", sync_cnt, 0);
        chk("early_in_frame", in_frame, 0);
        do_reset();

        // Line levels 1,1,0,0,0,1,1,0 decode to A5.
        drive_lvl(1); drive_lvl(1); drive_lvl(0); drive_lvl(0);
        drive_lvl(0); drive_lvl(1); drive_lvl(1); drive_lvl(0);
        chk("sync_pulse", sync_found, 1);
        chk("sync_in_frame", in_frame, 1);
        chk("sync_word_cnt", word_cnt, 0);
        @(negedge clk);
        chk("sync_pulse_end", sync_found, 0);

        for (int k = 0; k < 4; k++) begin
            send_word(fw[k], 0);
            chk("frame_valid", data_valid, 1);
            chk("frame_data", data_out, fw[k]);
            chk("frame_word_cnt", word_cnt, k + 1);
            chk("frame_in_frame", in_frame, (k < 3) ? 1 : 0);
        end
        idle(1);
        chk("frame_valid_end", data_valid, 0);
        chk("frame_cnt_hold", word_cnt, 4);
        chk("frame_data_hold", data_out, 8'h81);

        // Noise bits before the sync word, then a throttled frame.
        s0 = sync_cnt;
        drive_bit(1); drive_bit(1); drive_bit(0);
        send_word(8'hA5, 2);
        idle(1);
        chk("slide_one_sync", sync_cnt, s0 + 1);
        chk("slide_in_frame", in_frame, 1);
        q0 = words.size();
        for (int k = 0; k < 4; k++) send_word(tw[k], 2);
        idle(2);
        chk("thr_word_count", words.size(), q0 + 4);
        for (int k = 0; k < 4; k++) begin
            if (words.size() > q0 + k) chk("thr_data", words[q0 + k], tw[k]);
        end
        chk("thr_in_frame", in_frame, 0);
        chk("thr_word_cnt", word_cnt, 4);

        // Mid-frame reset after two words.
        send_word(8'hA5, 0);
        chk("mid_sync", sync_found, 1);
        send_word(8'h11, 0);
        send_word(8'h22, 0);
        chk("mid_second_word", data_out, 8'h22);
        #2 reset = 1'b1;
        #1;
        chk("async_data_valid", data_valid, 0);
        chk("async_in_frame",   in_frame,   0);
        chk("async_word_cnt",   word_cnt,   0);
        chk("async_data_out",   data_out,   0);
        line_lvl = 1'b0;
        line_in  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        v0 = valid_cnt;
        s0 = sync_cnt;
        send_word(8'h12, 0);
        send_word(8'h30, 0);
        idle(2);
        chk("abort_no_valid", valid_cnt, v0);
        chk("abort_no_sync", sync_cnt, s0);
        chk("abort_in_frame", in_frame, 0);

        // New frame restarts word_cnt, then a back-to-back sync.
        send_word(8'hA5, 0);
        chk("restart_sync", sync_found, 1);
        for (int k = 0; k < 4; k++) begin
            send_word(rw[k], 0);
            chk("restart_data", data_out, rw[k]);
            chk("restart_word_cnt", word_cnt, k + 1);
        end
        chk("restart_end_frame", in_frame, 0);
        send_word(8'hA5, 0);
        chk("b2b_sync", sync_found, 1);
        chk("b2b_in_frame", in_frame, 1);
        chk("b2b_word_cnt", word_cnt, 0);
        idle(2);

        chk("pulse_width", wide_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
